uart_char_rx: RTL and testbench

Asynchronous serial character receiver: oversamples the raw `i_rx` line, frames 8N1 characters and hands each received byte to the NMEA sentence parser as an 8-bit character with a one-cycle `o_finished` strobe. It sits directly upstream of the sentence receiver, which consumes `o_char`/`o_finished`. It also flags framing errors and recovers cleanly from break conditions.

---
 rtl/uart_char_rx.sv | 121 ++++++++++++
 tb/tb_uart_char_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver: synchronizes and oversamples i_rx, frames bytes
// LSB-first and strobes each good byte (o_finished) or a bad stop bit (o_frame_err).
module uart_char_rx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_char,
    output logic       o_finished,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             sync_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       char_q, char_d;
    logic             finished_q, finished_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic tick_half_c;
    logic tick_bit_c;

    assign tick_half_c = (cnt_q == HALF_M1);
    assign tick_bit_c  = (cnt_q == BIT_LAST);

    // State and datapath registers; the synchronizer idles high so reset is not a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= 8'h00;
            bit_q       <= 3'd0;
            char_q      <= 8'h00;
            finished_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= i_rx;
            rx_s_q      <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            char_q      <= char_d;
            finished_q  <= finished_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; STOP returns to IDLE at mid stop bit so a following start edge is not missed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!rx_s_q) state_d = START;
            START:     if (tick_half_c) state_d = rx_s_q ? IDLE : DATA;
            DATA:      if (tick_bit_c && (bit_q == 3'd7)) state_d = STOP;
            STOP:      if (tick_bit_c) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counter, shifter and registered output values.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        shift_d     = shift_q;
        bit_d       = 3'd0;
        char_d      = char_q;
        finished_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_d == START) || (state_d == DATA) || (state_d == STOP);

        if ((state_d != state_q) || ((state_q == DATA) && tick_bit_c)) begin
            cnt_d = '0;
        end

        if (state_q == DATA) begin
            bit_d = bit_q;
            if (tick_bit_c) begin
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
        end

        if ((state_q == STOP) && tick_bit_c) begin
            if (rx_s_q) begin
                char_d     = shift_q;
                finished_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign o_char      = char_q;
    assign o_finished  = finished_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Scoreboard bench for uart_char_rx: one instance at 16 clocks/bit for functional
// cases, one at 24 clocks/bit for bit-period tolerance.
module tb_uart_char_rx;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx1, rx2;
    logic [7:0] char1, char2;
    logic       fin1, fin2, err1, err2, busy1, busy2;

    int checks   = 0;
    int failures = 0;
    int n_fin1 = 0, n_err1 = 0, n_fin2 = 0;
    logic fin1_prev = 1'b0, fin2_prev = 1'b0;
    exp_t q1[$];
    exp_t q2[$];

    uart_char_rx #(.CLKS_PER_BIT(16)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_rx(rx1),
        .o_char(char1), .o_finished(fin1), .o_frame_err(err1), .o_busy(busy1)
    );

    uart_char_rx #(.CLKS_PER_BIT(24)) dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_rx(rx2),
        .o_char(char2), .o_finished(fin2), .o_frame_err(err2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one line level for n clocks; entered and left just after a rising edge.
    task automatic drive(input int which, input logic v, input int n);
        if (which == 1) rx1 = v; else rx2 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send an 8N1 frame; bit periods alternate pa/pb starting with the start bit.
    task automatic send(input int which, input logic [7:0] b, input int pa, input int pb,
                        input logic stop_v);
        drive(which, 1'b0, pa);
        for (int i = 0; i < 8; i++) drive(which, b[i], (i % 2 == 0) ? pb : pa);
        drive(which, stop_v, pb);
    endtask

    task automatic expect_char(input int which, input logic [7:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = v;
        if (which == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] held);
        exp_t e;
        e.is_err = 1'b1;
        e.val    = held;
        q1.push_back(e);
    endtask

    // Monitor for the 16 clocks/bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fin1 || err1) begin
                exp_t e;
                chk("dut1_fin_err_exclusive", 32'(fin1 && err1), 32'd0);
                chk("dut1_pulse_width", 32'(fin1_prev), 32'd0);
                if (fin1) n_fin1++;
                if (err1) n_err1++;
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_strobe", 32'(char1), 32'h1ff);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_strobe_kind", 32'(err1), 32'(e.is_err));
                    chk("dut1_char", 32'(char1), 32'(e.val));
                end
            end
        end
        fin1_prev <= fin1 | err1;
    end

    // Monitor for the 24 clocks/bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fin2 || err2) begin
                exp_t e;
                chk("dut2_pulse_width", 32'(fin2_prev), 32'd0);
                if (fin2) n_fin2++;
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_strobe", 32'(char2), 32'h1ff);
                end else begin
                    e = q2.pop_front();
                    chk("dut2_strobe_kind", 32'(err2), 32'(e.is_err));
                    chk("dut2_char", 32'(char2), 32'(e.val));
                end
            end
        end
        fin2_prev <= fin2 | err2;
    end

    initial begin
        logic [7:0] tol_bytes [6];
        logic [7:0] pre_reset_byte;
        int busy_cnt;

        tol_bytes[0] = 8'hA5; tol_bytes[1] = 8'h3C; tol_bytes[2] = 8'hF0;
        tol_bytes[3] = 8'h0F; tol_bytes[4] = 8'h81; tol_bytes[5] = 8'h7E;

        rst_n = 1'b0;
        rx1   = 1'b1;
        rx2   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_char", 32'(char1), 32'h00);
        chk("reset_finished", 32'(fin1), 32'd0);
        chk("reset_frame_err", 32'(err1), 32'd0);
        chk("reset_busy", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 1'b1, 10);

        // Single '$' character.
        expect_char(1, 8'h24);
        send(1, 8'h24, 16, 16, 1'b1);
        chk("busy_after_24", 32'(busy1), 32'd0);
        drive(1, 1'b1, 20);

        // Back-to-back sentence fragment, no idle gap.
        expect_char(1, 8'h47); send(1, 8'h47, 16, 16, 1'b1);
        expect_char(1, 8'h50); send(1, 8'h50, 16, 16, 1'b1);
        expect_char(1, 8'h0D); send(1, 8'h0D, 16, 16, 1'b1);
        expect_char(1, 8'h0A); send(1, 8'h0A, 16, 16, 1'b1);
        drive(1, 1'b1, 20);

        // 5-cycle low glitch must be rejected.
        drive(1, 1'b0, 5);
        rx1 = 1'b1;
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy1) busy_cnt++;
        end
        chk("glitch_busy_window", 32'((busy_cnt > 0) && (busy_cnt <= 8)), 32'd1);
        chk("glitch_busy_end", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        expect_char(1, 8'h2A);
        send(1, 8'h2A, 16, 16, 1'b1);
        drive(1, 1'b1, 20);

        // Framing error followed by a break held low.
        expect_err(8'h2A);
        send(1, 8'h55, 16, 16, 1'b0);
        rx1 = 1'b0;
        busy_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy1) busy_cnt++;
        end
        chk("break_no_retrigger", 32'(busy_cnt), 32'd0);
        chk("break_char_held", 32'(char1), 32'h2A);
        @(posedge clk); #1;
        drive(1, 1'b1, 30);
        expect_char(1, 8'h2A);
        send(1, 8'h2A, 16, 16, 1'b1);
        drive(1, 1'b1, 20);

        // Reset during data bit 4 of 0x7E.
        pre_reset_byte = 8'h7E;
        drive(1, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1, pre_reset_byte[i], 16);
        drive(1, pre_reset_byte[4], 8);
        rst_n = 1'b0;
        #1;
        chk("midreset_char", 32'(char1), 32'h00);
        chk("midreset_finished", 32'(fin1), 32'd0);
        chk("midreset_frame_err", 32'(err1), 32'd0);
        chk("midreset_busy", 32'(busy1), 32'd0);
        rx1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1'b1, 20);
        expect_char(1, 8'h31);
        send(1, 8'h31, 16, 16, 1'b1);
        drive(1, 1'b1, 20);

        // Bit-period tolerance at 24 clocks/bit: fast (23/24) then slow (24/25).
        for (int i = 0; i < 6; i++) begin
            expect_char(2, tol_bytes[i]);
            send(2, tol_bytes[i], 23, 24, 1'b1);
        end
        drive(2, 1'b1, 30);
        for (int i = 0; i < 6; i++) begin
            expect_char(2, tol_bytes[i]);
            send(2, tol_bytes[i], 25, 24, 1'b1);
        end
        drive(2, 1'b1, 40);

        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
        chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
        chk("dut1_finished_count", 32'(n_fin1), 32'd8);
        chk("dut1_frame_err_count", 32'(n_err1), 32'd1);
        chk("dut2_finished_count", 32'(n_fin2), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
